puf_auth_controller: RTL

Challenge/response driver that sits on the host side of the 8-bit ring-oscillator PUF. It issues a fixed sequence of challenges and waits for each response handshake. In enroll mode it stores the responses as a golden table; in verify mode it scores fresh responses against that table by Hamming distance and reports pass/fail.

---
 rtl/puf_pkg.sv | 18 +
 rtl/puf_popcount8.sv | 14 +
 rtl/puf_auth_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF authentication controller.
package puf_pkg;

    localparam int RESP_W  = 8;
    localparam int CHALL_W = 8;

    localparam logic MODE_ENROLL = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        RUN,
        CAPTURE,
        FINISH
    } state_t;

endpackage

// File: rtl/puf_popcount8.sv
// Combinational population count of an 8-bit word.
module puf_popcount8 (
    input  logic [7:0] data,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, data[i]};
        end
    end

endmodule

// File: rtl/puf_auth_controller.sv
// Host-side PUF challenge/response driver: enrolls a golden table or scores a
// fresh run against it by Hamming distance. Optional timeout: PUF_AUTH_TIMEOUT_EN.
module puf_auth_controller
    import puf_pkg::*;
#(
    parameter int               NUM_CHALL  = 16,
    parameter logic [7:0]       CHALL_SEED = 8'hA5,
    parameter int               HD_THRESH  = 12,
    parameter int               TIMEOUT    = 4096,
    localparam int              HD_W       = $clog2(NUM_CHALL*8+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                err,
    output logic [HD_W-1:0]     hd_total,
    output logic                enrolled,
    output logic                puf_en,
    output logic                puf_rst,
    output logic [CHALL_W-1:0]  puf_chall,
    input  logic [RESP_W-1:0]   puf_response,
    input  logic                puf_ready
);

    localparam int              IDX_W    = (NUM_CHALL > 1) ? $clog2(NUM_CHALL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHALL - 1);
    localparam logic [HD_W-1:0] HD_MAX   = {HD_W{1'b1}};
    localparam logic [31:0]     THRESH_U = 32'(HD_THRESH);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx;
    logic               mode_q;
    logic               run_first;
    logic               set_err;
    logic [RESP_W-1:0]  golden [NUM_CHALL];
    logic [3:0]         pc_count;
    logic [HD_W:0]      hd_sum;
    logic [HD_W-1:0]    hd_next;

`ifdef PUF_AUTH_TIMEOUT_EN
    localparam int      TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    to_cnt;
`else
    // TIMEOUT only shapes logic when the timeout counter is built.
    logic               unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign puf_chall = CHALL_SEED + CHALL_W'(idx);

    puf_popcount8 u_popcount (
        .data  (puf_response ^ golden[idx]),
        .count (pc_count)
    );

    always_comb begin
        hd_sum  = {1'b0, hd_total} + (HD_W+1)'(pc_count);
        hd_next = (hd_sum > {1'b0, HD_MAX}) ? HD_MAX : hd_sum[HD_W-1:0];
    end

    always_comb begin
        state_n = state;
        set_err = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        puf_en  = 1'b0;
        puf_rst = 1'b0;
        case (state)
            IDLE: begin
                puf_rst = 1'b1;
                if (start) begin
                    if (mode == MODE_VERIFY && !enrolled) begin
                        state_n = FINISH;
                        set_err = 1'b1;
                    end else begin
                        state_n = APPLY;
                    end
                end
            end
            APPLY: begin
                busy    = 1'b1;
                puf_rst = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                puf_en = 1'b1;
                // A ready seen in the first RUN cycle is left over from the previous challenge.
                if (!run_first && puf_ready) begin
                    state_n = CAPTURE;
                end
`ifdef PUF_AUTH_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_n = FINISH;
                    set_err = 1'b1;
                end
`endif
            end
            CAPTURE: begin
                busy    = 1'b1;
                state_n = (idx == LAST_IDX) ? FINISH : APPLY;
            end
            FINISH: begin
                done    = 1'b1;
                puf_rst = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            mode_q    <= MODE_ENROLL;
            run_first <= 1'b0;
            err       <= 1'b0;
            pass      <= 1'b0;
            hd_total  <= '0;
            enrolled  <= 1'b0;
            for (int i = 0; i < NUM_CHALL; i++) begin
                golden[i] <= '0;
            end
`ifdef PUF_AUTH_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        idx      <= '0;
                        err      <= 1'b0;
                        pass     <= 1'b0;
                        hd_total <= '0;
                    end
                end
                APPLY: begin
                    run_first <= 1'b1;
`ifdef PUF_AUTH_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                end
                RUN: begin
                    run_first <= 1'b0;
`ifdef PUF_AUTH_TIMEOUT_EN
                    to_cnt    <= to_cnt + TO_W'(1);
`endif
                end
                CAPTURE: begin
                    if (mode_q == MODE_ENROLL) begin
                        golden[idx] <= puf_response;
                    end else begin
                        hd_total <= hd_next;
                    end
                    if (idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                FINISH: begin
                    if (mode_q == MODE_ENROLL) begin
                        if (!err) begin
                            enrolled <= 1'b1;
                        end
                    end else begin
                        pass <= ({{(32-HD_W){1'b0}}, hd_total} <= THRESH_U) && !err;
                    end
                end
                default: ;
            endcase
            // Abort flag wins over the clear done on the start edge.
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule
